// File: rtl/ll_head_table_pkg.sv
// ll_head_table_pkg: shared widths, entry type and FSM states for the head-pointer table
package ll_head_table_pkg;
  localparam int LL_HEAD_PTR_WIDTH  = 16;
  localparam int LL_HEAD_ADDR_WIDTH = 10;
  typedef struct packed {
    logic [LL_HEAD_PTR_WIDTH-1:0] ptr;
    logic                         val;
  } ll_head_entry_t;
  typedef enum logic {LL_HT_IDLE, LL_HT_CLEAR} ll_ht_state_t;
endpackage

// File: rtl/ll_head_table_ram.sv
// ll_head_table_ram: simple dual-port 1R1W memory with registered, enabled read port
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data
// (updates only when re=1, so it holds between reads). No reset on the array.
module ll_head_table_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 17
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end
endmodule

// File: rtl/ll_head_table.sv
// ll_head_table: per-bucket head pointer + valid storage with self-clearing sweep
// Ports: clk, rst_n (async, active low); init_i pulse starts a clear sweep, init_busy_o while sweeping;
// write port wr_addr_i/wr_data_ptr/wr_data_ptr_val/wr_en, accepted when wr_ready_o;
// read port rd_addr_i/rd_en_i, one cycle later rd_valid_o with rd_ptr_o/rd_ptr_val_o.
module ll_head_table
  import ll_head_table_pkg::*;
#(
  parameter int NUM_HEADS = 1024,
  parameter int ADDR_W    = $clog2(NUM_HEADS),
  parameter int PTR_W     = LL_HEAD_PTR_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_i,
  output logic              init_busy_o,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PTR_W-1:0]  wr_data_ptr,
  input  logic              wr_data_ptr_val,
  input  logic              wr_en,
  output logic              wr_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_en_i,
  output logic              rd_valid_o,
  output logic [PTR_W-1:0]  rd_ptr_o,
  output logic              rd_ptr_val_o
);
  localparam logic [ADDR_W:0]   NUM  = (ADDR_W+1)'(NUM_HEADS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_HEADS - 1);
  ll_ht_state_t      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              use_ram_q, use_ram_d;
  logic [PTR_W:0]    byp_q, byp_d;
  logic              wr_in, rd_in, user_wr, hit;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_waddr;
  logic [PTR_W:0]    ram_wdata, ram_rdata, user_wdata;
  assign init_busy_o = state_q == LL_HT_CLEAR;
  assign wr_ready_o  = !init_busy_o;
  assign wr_in       = {1'b0, wr_addr_i} < NUM;
  assign rd_in       = {1'b0, rd_addr_i} < NUM;
  assign user_wr     = wr_en && wr_ready_o && wr_in;
  assign user_wdata  = {wr_data_ptr, wr_data_ptr_val};
  assign hit         = user_wr && wr_addr_i == rd_addr_i;
  assign ram_we      = init_busy_o || user_wr;
  assign ram_waddr   = init_busy_o ? cnt_q : wr_addr_i;
  assign ram_wdata   = init_busy_o ? '0 : user_wdata;
  assign ram_re      = rd_en_i && rd_in;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (init_i) begin
      state_d = LL_HT_CLEAR;
      cnt_d   = '0;
    end else if (init_busy_o) begin
      state_d = cnt_q == LAST ? LL_HT_IDLE : LL_HT_CLEAR;
      cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
    end
  end
  // The RAM read port only serves in-range reads outside the sweep with no
  // same-address write; everything else (zero or write-first data) comes from
  // the bypass register. Both only update on rd_en_i, so the output holds.
  always_comb begin
    rd_valid_d = rd_en_i;
    use_ram_d  = use_ram_q;
    byp_d      = byp_q;
    if (rd_en_i) begin
      use_ram_d = rd_in && !init_busy_o && !hit;
      byp_d     = hit ? user_wdata : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LL_HT_CLEAR;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      use_ram_q  <= 1'b0;
      byp_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      use_ram_q  <= use_ram_d;
      byp_q      <= byp_d;
    end
  end
  ll_head_table_ram #(.DEPTH(NUM_HEADS), .AW(ADDR_W), .DW(PTR_W + 1)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(rd_addr_i),
    .rdata(ram_rdata)
  );
  assign rd_valid_o              = rd_valid_q;
  assign {rd_ptr_o, rd_ptr_val_o} = use_ram_q ? ram_rdata : byp_q;
endmodule
